// File: rtl/serial_paralelo_phy.sv
// rtl/serial_paralelo_phy.sv - serial symbol aligner: finds 0xBC comma, locks, extracts data bytes
module serial_paralelo_phy #(
    parameter int unsigned BC_LOCK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sync_out,
    output logic       active_out
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCK   = 2'd2
    } state_e;

    localparam logic [7:0] SYM_BC    = 8'hBC;
    localparam logic [7:0] SYM_7C    = 8'h7C;
    localparam logic [3:0] BC_LOCK_C = 4'(BC_LOCK);

    state_e     state_q, state_d;
    logic [7:0] shift_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] bc_cnt_q, bc_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       sync_q, sync_d;
    logic       active_q, active_d;

    logic [7:0] candidate;
    logic       boundary;

    assign candidate = {shift_q[6:0], data_in};
    assign boundary  = (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= SEARCH;
            shift_q   <= 8'h00;
            bit_cnt_q <= 3'd0;
            bc_cnt_q  <= 4'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= candidate;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sync_q    <= sync_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        case (state_q)
            SEARCH: begin
                // Unaligned hunt: any bit position may start a comma
                bit_cnt_d = 3'd0;
                if (candidate == SYM_BC) begin
                    bc_cnt_d = 4'd1;
                    state_d  = ALIGN;
                end
            end
            ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (candidate == SYM_BC) begin
                        bc_cnt_d = (bc_cnt_q >= BC_LOCK_C) ? BC_LOCK_C : bc_cnt_q + 4'd1;
                        if (bc_cnt_d == BC_LOCK_C) begin
                            state_d = LOCK;
                        end
                    end else begin
                        bc_cnt_d  = 4'd0;
                        bit_cnt_d = 3'd0;
                        state_d   = SEARCH;
                    end
                end
            end
            LOCK: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            default: begin
                state_d   = SEARCH;
                bit_cnt_d = 3'd0;
                bc_cnt_d  = 4'd0;
            end
        endcase
    end

    always_comb begin
        data_d   = data_q;
        valid_d  = 1'b0;
        active_d = active_q;
        sync_d   = (state_d == LOCK);
        if ((state_q == LOCK) && boundary) begin
            if (candidate == SYM_BC) begin
                active_d = 1'b0;
            end else if (candidate == SYM_7C) begin
                active_d = 1'b1;
            end else begin
                data_d  = candidate;
                valid_d = 1'b1;
            end
        end
        if (state_d != LOCK) begin
            active_d = 1'b0;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign sync_out   = sync_q;
    assign active_out = active_q;

endmodule

// File: doc/serial_paralelo_phy.md
SERIAL_PARALELO_PHY -- requirements
Module: serial_paralelo_phy

Interface
REQ-001 The block SHALL have one parameter: BC_LOCK, default 4, meaning the number of consecutive aligned 0xBC symbols that are required to declare lock (legal range 2..15).
REQ-002 The block SHALL have the port: clk  input  1  bit clock; one serial bit is sampled per rising edge.
REQ-003 The block SHALL have the port: reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have the port: data_in  input  1  serial symbol stream, MSB first.
REQ-005 The block SHALL have the port: data_out  output  8  last received data byte.
REQ-006 The block SHALL have the port: valid_out  output  1  one-cycle pulse indicating that data_out was just loaded.
REQ-007 The block SHALL have the port: sync_out  output  1  high while in the LOCK state.
REQ-008 The block SHALL have the port: active_out  output  1  link-active indication decoded from the 0xBC/0x7C symbols.
REQ-009 Reset SHALL be asynchronous and active-low; all outputs SHALL be registered.

Function
REQ-010 Internal storage SHALL consist of an 8-bit shift register, a 3-bit bit counter and a 4-bit BC counter; every rising edge SHALL shift data_in into the LSB.
REQ-011 The candidate byte SHALL be {shift[6:0], data_in}; the first transmitted bit lands in bit 7.
REQ-012 The FSM SHALL have exactly three states, SEARCH, ALIGN and LOCK; the reset state SHALL be SEARCH.
REQ-013 In SEARCH, the candidate byte SHALL be checked on every edge, with no byte boundary applied.
REQ-014 In SEARCH, a candidate byte equal to 0xBC SHALL set the bit counter to 0, set the BC counter to 1 and move the FSM to ALIGN.
REQ-015 In ALIGN and LOCK, the bit counter SHALL increment on every edge and wrap from 7 to 0.
REQ-016 A byte boundary SHALL be the edge at which the bit counter equals 7.
REQ-017 In ALIGN, at a byte boundary with candidate 0xBC, the BC counter SHALL increment.
REQ-018 In ALIGN, if the incremented BC counter equals BC_LOCK, the FSM SHALL go to LOCK and sync_out SHALL rise on that same edge.
REQ-019 In ALIGN, at a byte boundary with any candidate other than 0xBC, the FSM SHALL return to SEARCH and clear the BC counter.
REQ-020 In ALIGN, the search for a new 0xBC SHALL resume on the next edge, not on the failing byte.
REQ-021 In LOCK, at a byte boundary with candidate 0xBC, active_out SHALL be set to 0 and valid_out SHALL be 0.
REQ-022 In LOCK, at a byte boundary with candidate 0x7C, active_out SHALL be set to 1 and valid_out SHALL be 0.
REQ-023 In LOCK, at a byte boundary with any other candidate, data_out SHALL load the candidate and valid_out SHALL be 1 for exactly the following cycle.
REQ-024 A data byte in LOCK SHALL leave active_out unchanged.
REQ-025 Latency SHALL be: valid_out and data_out update on the same edge that samples the 8th bit of a byte.
REQ-026 valid_out SHALL be 0 on every non-boundary edge and in the SEARCH and ALIGN states.
REQ-027 data_out SHALL hold its value between loads.
REQ-028 LOCK SHALL be exited only by reset.
REQ-029 sync_out SHALL remain 1 in LOCK regardless of the content of the symbols received.
REQ-030 active_out SHALL be 0 in SEARCH and ALIGN.
REQ-031 The BC counter SHALL saturate at BC_LOCK and SHALL never wrap.

Reset
REQ-032 While reset=0, the outputs SHALL be data_out=0x00, valid_out=0, sync_out=0 and active_out=0.
REQ-033 While reset=0, the internal state SHALL be shift=0x00, bit counter=0, BC counter=0 and FSM=SEARCH.
REQ-034 Assertion of reset at any time, including mid-byte or in LOCK, SHALL take effect immediately without waiting for clk.
REQ-035 After deassertion, the first 0xBC detection SHALL require at least 8 fresh bits.

Verification
REQ-036 The bench SHALL cover: after reset, 4 back-to-back 0xBC at an arbitrary bit offset (3 garbage bits first) -> sync_out=1 on the 32nd bit edge of the 0xBC sequence, with active_out=0 and valid_out never asserted.
REQ-037 The bench SHALL cover: after lock, send 0x7C, then 0x5A, then 0xBC -> active_out=1 after 0x7C; data_out=0x5A with a single-cycle valid_out; active_out=0 after 0xBC.
REQ-038 The bench SHALL cover: 0xBC, 0xBC, 0x13, then 4x 0xBC -> return to SEARCH at the 0x13 boundary, lock only after the last of the 4 following 0xBC, and no valid_out during the sequence.
REQ-039 The bench SHALL cover: BC_LOCK=2 override -> sync_out=1 after 2 consecutive 0xBC.
REQ-040 The bench SHALL cover: reset pulled low at bit 4 of a data byte while in LOCK -> all outputs 0 immediately, with no further valid_out until relocked.
REQ-041 The bench SHALL cover: a stream of 0x00 or 0xFF for 64 bits -> sync_out stays 0 and valid_out stays 0.
